// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: DATA_W-bit MSB-first words, CLK_DIV clk cycles per SCK half-period, all CPOL/CPHA modes.
// Optional build macro SPI_LOOPBACK_EN adds a per-transfer loopback input that routes internal MOSI into the receive path.
`timescale 1ns/1ps

module spi_master_param #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 1,
   parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback,
`endif
   input  logic              MISO,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              MOSI,
   output logic              SCK,
   output logic [NUM_CS-1:0] CS_n
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGES  = 2 * DATA_W;
   localparam int EDGE_W = $clog2(EDGES + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_HOLD
   } state_e;

   state_e              state_q,  state_d;
   logic [DIV_W-1:0]    div_q,    div_d;
   logic [EDGE_W-1:0]   edge_q,   edge_d;
   logic [DATA_W-1:0]   shreg_q,  shreg_d;
   logic [DATA_W-1:0]   rx_q,     rx_d;
   logic [NUM_CS-1:0]   cs_n_q,   cs_n_d;
   logic                mosi_q,   mosi_d;
   logic                sck_q,    sck_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic                cpol_q,   cpol_d;
   logic                cpha_q,   cpha_d;
`ifdef SPI_LOOPBACK_EN
   logic                lb_q,     lb_d;
`endif

   logic div_tick;
   logic sck_edge;
   logic leading;
   logic last_edge;
   logic rx_bit;

   // Out-of-range selects leave every chip select high; the transfer still clocks.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NUM_CS-1:0] mask;
      mask = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (int'(sel) == i) mask[i] = 1'b0;
      end
      return mask;
   endfunction

`ifdef SPI_LOOPBACK_EN
   assign rx_bit = lb_q ? mosi_q : MISO;
`else
   assign rx_bit = MISO;
`endif

   assign div_tick  = (div_q == DIV_LAST);
   assign leading   = ~edge_q[0];
   assign last_edge = (edge_q == EDGE_LAST);

   always_comb begin
      // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d  = state_q;
      div_d    = div_q;
      edge_d   = edge_q;
      shreg_d  = shreg_q;
      rx_d     = rx_q;
      cs_n_d   = cs_n_q;
      mosi_d   = mosi_q;
      sck_d    = sck_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
`ifdef SPI_LOOPBACK_EN
      lb_d     = lb_q;
`endif
      sck_edge = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            div_d  = '0;
            edge_d = '0;
            if (start) begin
               state_d = S_SETUP;
               busy_d  = 1'b1;
               shreg_d = tx_data;
               cpol_d  = cpol;
               cpha_d  = cpha;
               sck_d   = cpol;
               cs_n_d  = cs_decode(cs_sel);
`ifdef SPI_LOOPBACK_EN
               lb_d    = loopback;
`endif
               // With cpha=1 the first bit only appears on the leading edge.
               if (!cpha) mosi_d = tx_data[DATA_W-1];
            end
         end

         S_SETUP, S_XFER: begin
            div_d    = div_tick ? '0 : div_q + DIV_W'(1);
            sck_edge = div_tick;
            if (div_tick && (state_q == S_SETUP)) state_d = S_XFER;
         end

         S_HOLD: begin
            div_d = div_tick ? '0 : div_q + DIV_W'(1);
            sck_d = cpol_q;
            if (div_tick) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               rx_d    = shreg_q;
               cs_n_d  = '1;
               edge_d  = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // One register serves both directions: MSB drives MOSI, sampled bits enter at the LSB.
      if (sck_edge) begin
         sck_d  = ~sck_q;
         edge_d = edge_q + EDGE_W'(1);
         if (leading ^ cpha_q) begin
            shreg_d = {shreg_q[DATA_W-2:0], rx_bit};
         end else if (!last_edge) begin
            mosi_d = shreg_q[DATA_W-1];
         end
         if (last_edge) state_d = S_HOLD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         shreg_q <= '0;
         rx_q    <= '0;
         cs_n_q  <= '1;
         mosi_q  <= 1'b0;
         sck_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
`ifdef SPI_LOOPBACK_EN
         lb_q    <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         shreg_q <= shreg_d;
         rx_q    <= rx_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         sck_q   <= sck_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
`ifdef SPI_LOOPBACK_EN
         lb_q    <= lb_d;
`endif
      end
   end

   assign rx_data = rx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign MOSI    = mosi_q;
   assign SCK     = sck_q;
   assign CS_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param (DATA_W=8, CLK_DIV=4, NUM_CS=4): per-cycle reference model,
// an SPI slave that answers on MISO and records MOSI, directed corner cases and randomized transfers.
`timescale 1ns/1ps

module tb_spi_master_param;

   localparam int DW    = 8;
   localparam int CD    = 4;
   localparam int NCS   = 4;
   localparam int CSW   = 2;
   localparam int EDGES = 2 * DW;
   localparam int T     = (2 * DW + 1) * CD;  // clk edges from accept to done

   logic           clk     = 1'b0;
   logic           rst_n   = 1'b0;
   logic           start   = 1'b0;
   logic [DW-1:0]  tx_data = '0;
   logic [CSW-1:0] cs_sel  = '0;
   logic           cpol    = 1'b0;
   logic           cpha    = 1'b0;
   logic           miso    = 1'b0;
   logic           tb_lb   = 1'b0;
   logic [DW-1:0]  rx_data;
   logic           busy, done, mosi, sck;
   logic [NCS-1:0] cs_n;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_master_param #(
      .DATA_W (DW),
      .CLK_DIV(CD),
      .NUM_CS (NCS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .tx_data (tx_data),
      .cs_sel  (cs_sel),
      .cpol    (cpol),
      .cpha    (cpha),
`ifdef SPI_LOOPBACK_EN
      .loopback(tb_lb),
`endif
      .MISO    (miso),
      .rx_data (rx_data),
      .busy    (busy),
      .done    (done),
      .MOSI    (mosi),
      .SCK     (sck),
      .CS_n    (cs_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NCS-1:0] sel_mask(input int s);
      logic [NCS-1:0] m;
      m = '1;
      if (s < NCS) m[s] = 1'b0;
      return m;
   endfunction

   // Reference model: m_t counts clk edges since the accepting edge.
   logic [DW-1:0] next_slave = '0;
   bit            m_active   = 1'b0;
   int            m_t        = 0;
   logic [DW-1:0] m_tx       = '0;
   logic [DW-1:0] m_slave    = '0;
   logic [DW-1:0] m_rx       = '0;
   int            m_cs       = 0;
   bit            m_cpol     = 1'b0;
   bit            m_cpha     = 1'b0;
   bit            m_lb       = 1'b0;
   bit            m_hold     = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_t      <= 0;
         m_rx     <= '0;
         m_cpol   <= 1'b0;
         m_hold   <= 1'b0;
      end else begin
         if (m_active && m_t < T) begin
            m_t <= m_t + 1;
            if (m_t + 1 == T) begin
               m_rx   <= m_lb ? m_tx : m_slave;
               m_hold <= m_tx[0];
            end
         end else if (m_active) begin
            m_active <= 1'b0;
         end
         if (start && (!m_active || m_t == T)) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_tx     <= tx_data;
            m_slave  <= next_slave;
            m_cs     <= int'(cs_sel);
            m_cpol   <= cpol;
            m_cpha   <= cpha;
            m_lb     <= tb_lb;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      int k;
      int idx;
      logic emosi, esck;
      logic [NCS-1:0] ecs;
      if (rst_n) begin
         if (m_active) begin
            k = m_t / CD;
            if (k > EDGES) k = EDGES;
            esck = m_cpol ^ (k % 2 == 1);
            if (!m_cpha) begin
               idx   = (k / 2 > DW - 1) ? 0 : DW - 1 - k / 2;
               emosi = m_tx[idx];
            end else if (k == 0) begin
               emosi = m_hold;
            end else begin
               idx   = ((k - 1) / 2 > DW - 1) ? 0 : DW - 1 - (k - 1) / 2;
               emosi = m_tx[idx];
            end
            ecs = (m_t < T) ? sel_mask(m_cs) : '1;
            check("cyc_busy", busy, 1'b1);
            check("cyc_done", done, (m_t == T));
         end else begin
            esck  = m_cpol;
            emosi = m_hold;
            ecs   = '1;
            check("cyc_busy", busy, 1'b0);
            check("cyc_done", done, 1'b0);
         end
         check("cyc_sck", sck, esck);
         check("cyc_mosi", mosi, emosi);
         check("cyc_cs_n", cs_n, ecs);
         check("cyc_rx", rx_data, m_rx);
      end
   end

   // SPI slave: shifts its word out on MISO and records what it receives on MOSI.
   bit            s_on = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_lead = 1'b0, s_prev = 1'b0;
   logic [DW-1:0] s_word = '0, s_cap = '0, last_cap = '0;
   int            s_out = 0, s_edges = 0, last_edges = 0;

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         s_on = 1'b0;
         miso = 1'b0;
      end else if (m_active && m_t == 0) begin
         s_on    = 1'b1;
         s_word  = m_slave;
         s_cpol  = m_cpol;
         s_cpha  = m_cpha;
         s_lead  = 1'b0;
         s_cap   = '0;
         s_edges = 0;
         s_out   = 0;
         if (!m_cpha) begin
            miso  = m_slave[DW-1];
            s_out = 1;
         end
      end else if (s_on && sck != s_prev) begin
         if (sck != s_cpol) begin
            s_lead = 1'b1;
            s_edges++;
            if (!s_cpha) s_cap = {s_cap[DW-2:0], mosi};
            else if (s_out < DW) begin
               miso = s_word[DW-1-s_out];
               s_out++;
            end
         end else if (s_lead) begin
            s_lead = 1'b0;
            s_edges++;
            if (s_cpha) s_cap = {s_cap[DW-2:0], mosi};
            else if (s_out < DW) begin
               miso = s_word[DW-1-s_out];
               s_out++;
            end
         end
      end
      if (s_on && m_active && m_t == T) begin
         check("slave_rx_word", s_cap, m_tx);
         check("slave_edge_count", s_edges, EDGES);
         last_cap   = s_cap;
         last_edges = s_edges;
         s_on       = 1'b0;
      end
      s_prev = sck;
   end

   // Called at a negedge; returns at the negedge of the cycle after the accepting edge.
   task automatic do_start(input logic [DW-1:0] tx, input int cs, input bit pol, input bit pha,
                           input bit l, input logic [DW-1:0] sw);
      tx_data    = tx;
      cs_sel     = CSW'(cs);
      cpol       = pol;
      cpha       = pha;
      tb_lb      = l;
      next_slave = sw;
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_done(input int poke_at, input bit scramble,
                            output int cyc, output int cs_low, output int gaps);
      cyc    = 0;
      cs_low = 0;
      gaps   = 0;
      while (done !== 1'b1 && cyc < 400) begin
         if (cs_n != '1) cs_low++;
         if (busy !== 1'b1) gaps++;
         start = (cyc == poke_at);
         if (scramble) begin
            tx_data = DW'($urandom);
            cs_sel  = CSW'($urandom);
            cpol    = 1'($urandom);
            cpha    = 1'($urandom);
`ifdef SPI_LOOPBACK_EN
            tb_lb   = 1'($urandom);
`endif
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("done_seen", done, 1'b1);
   endtask

   initial begin
      int cyc, csl, gaps, dcount, gap, poke;
      logic [DW-1:0] rtx, rsw;

      repeat (3) @(negedge clk);
      check("rst_rx", rx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_sck", sck, 1'b0);
      check("rst_cs_n", cs_n, 4'hF);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Mode 0, tx 0xA5, slave answers 0x3C; busy appears in cycle N+1, done in N+69.
      do_start(8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'h3C);
      wait_done(-1, 1'b0, cyc, csl, gaps);
      check("m0_done_cycle", cyc + 1, 69);
      check("m0_rx", rx_data, 8'h3C);
      check("m0_cs_low_cycles", csl, 68);
      check("m0_busy_gaps", gaps, 0);
      check("m0_slave_saw", last_cap, 8'hA5);
      @(negedge clk);
      check("m0_done_single", done, 1'b0);
      check("m0_busy_off", busy, 1'b0);

      // Mode 3, tx 0x81, slave answers 0x7E.
      do_start(8'h81, 1, 1'b1, 1'b1, 1'b0, 8'h7E);
      wait_done(-1, 1'b1, cyc, csl, gaps);
      check("m3_rx", rx_data, 8'h7E);
      check("m3_edges", last_edges, 16);
      check("m3_slave_saw", last_cap, 8'h81);
      @(negedge clk);
      check("m3_sck_idle_high", sck, 1'b1);

      // Start pulsed mid-transfer is ignored.
      do_start(8'h3B, 0, 1'b0, 1'b1, 1'b0, 8'hD2);
      wait_done(10, 1'b1, cyc, csl, gaps);
      check("poke_done_cycle", cyc + 1, 69);
      check("poke_busy_gaps", gaps, 0);
      @(negedge clk);
      check("poke_done_single", done, 1'b0);

      // Asynchronous reset in cycle N+30.
      do_start(8'h5A, 0, 1'b1, 1'b0, 1'b0, 8'h99);
      repeat (29) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cs_n", cs_n, 4'hF);
      check("arst_sck", sck, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_rx", rx_data, 8'h00);
      check("arst_done", done, 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      dcount = 0;
      repeat (100) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      check("arst_no_done", dcount, 0);

      // Chip-select decode and back-to-back accept on the done cycle.
      do_start(8'h6C, 2, 1'b0, 1'b0, 1'b0, 8'h17);
      repeat (5) @(negedge clk);
      check("cs2_only", cs_n, 4'b1011);
      wait_done(-1, 1'b1, cyc, csl, gaps);
      check("cs2_release", cs_n, 4'hF);
      do_start(8'hE1, 3, 1'b0, 1'b0, 1'b0, 8'h4D);
      check("cs3_b2b", cs_n, 4'b0111);
      check("cs3_busy", busy, 1'b1);
      wait_done(-1, 1'b1, cyc, csl, gaps);
      check("cs3_rx", rx_data, 8'h4D);

`ifdef SPI_LOOPBACK_EN
      do_start(8'hC3, 0, 1'b0, 1'b0, 1'b1, 8'h00);
      wait_done(-1, 1'b0, cyc, csl, gaps);
      check("lb_rx", rx_data, 8'hC3);
`endif

      for (int i = 0; i < 30; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         rtx  = DW'($urandom);
         rsw  = DW'($urandom);
         poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : -1;
`ifdef SPI_LOOPBACK_EN
         do_start(rtx, $urandom_range(0, NCS - 1), 1'($urandom), 1'($urandom), 1'($urandom), rsw);
`else
         do_start(rtx, $urandom_range(0, NCS - 1), 1'($urandom), 1'($urandom), 1'b0, rsw);
`endif
         wait_done(poke, 1'b1, cyc, csl, gaps);
         check("rand_busy_gaps", gaps, 0);
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1);
   end

endmodule
